// File: rtl/minsum_pkg.sv
// Shared types and helpers for the serial min-sum check-node layer: FSM states,
// saturated magnitude and sign extraction on sign-extended 32-bit values.
package minsum_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

   function automatic logic [31:0] maxm(input int unsigned n_fp);
      return (32'd1 << (n_fp - 1)) - 32'd1;
   endfunction

   // The most negative code has no positive twin, so it clamps to the largest magnitude.
   function automatic logic [31:0] sat_mag(input logic signed [31:0] x, input int unsigned n_fp);
      logic [31:0] a;
      a = x[31] ? 32'(-x) : 32'(x);
      if (a > maxm(n_fp))
         a = maxm(n_fp);
      return a;
   endfunction

   function automatic logic sign_of(input logic signed [31:0] x);
      return x[31];
   endfunction

endpackage

// File: rtl/minsum_cn_acc.sv
// One check node's running min1/min2/idx1/parity, plus the extrinsic magnitude
// select for the edge currently presented on edge_idx.
module minsum_cn_acc
   import minsum_pkg::*;
#(
   parameter int MW = 7,
   parameter int IW = 8,
   parameter int E  = 147
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic          upd,
   input  logic [IW-1:0] edge_idx,
   input  logic [MW-1:0] mag_in,
   input  logic          sgn_in,
   output logic [MW-1:0] ext_mag,
   output logic          par
);

   localparam logic [MW-1:0] MAXM = MW'(maxm(MW + 1));
   localparam logic [IW-1:0] NONE = IW'(E);

   logic [MW-1:0] min1;
   logic [MW-1:0] min2;
   logic [IW-1:0] idx1;

   // Strict compares keep the earliest edge as idx1 when magnitudes tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min1 <= MAXM;
         min2 <= MAXM;
         idx1 <= NONE;
         par  <= 1'b0;
      end else if (init) begin
         min1 <= MAXM;
         min2 <= MAXM;
         idx1 <= NONE;
         par  <= 1'b0;
      end else if (upd) begin
         par <= par ^ sgn_in;
         if (mag_in < min1) begin
            min2 <= min1;
            min1 <= mag_in;
            idx1 <= edge_idx;
         end else if (mag_in < min2) begin
            min2 <= mag_in;
         end
      end
   end

   assign ext_mag = (edge_idx == idx1) ? min2 : min1;

endmodule

// File: rtl/check_nodes_serial.sv
// Serial min-sum check-node update: one edge per clock, a SCAN pass then a WRITE pass.
// Define CHECK_OFFSET_EN to subtract OFFSET from each output magnitude (offset min-sum).
module check_nodes_serial
   import minsum_pkg::*;
#(
   parameter int N_C    = 12,
   parameter int E      = 147,
   parameter int N_FP   = 8,
   parameter int OFFSET = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [0:N_C-1][0:E-1]   adj_matrix_out,
   input  logic signed [N_FP-1:0]  prev_proc_elem [0:E-1],
   output logic                    busy,
   output logic                    done,
   output logic signed [N_FP-1:0]  proc_elem [0:E-1]
);

   localparam int MW = N_FP - 1;
   localparam int IW = $clog2(E + 1);
   localparam int CW = (N_C > 1) ? $clog2(N_C) : 1;
   localparam logic [IW-1:0] LAST = IW'(E - 1);

   state_t               state;
   logic [IW-1:0]        cnt;
   logic [CW-1:0]        chk_idx;
   logic                 orphan;
   logic signed [N_FP-1:0] cur;
   logic [MW-1:0]        mag;
   logic                 sgn;
   logic                 acc_init;
   logic                 scan_upd;
   logic [MW-1:0]        ext_mag [N_C];
   logic                 par [N_C];
   logic [MW-1:0]        sel_mag;
   logic [MW-1:0]        out_mag;
   logic                 sel_sgn;
   logic [N_FP-1:0]      pos;
   logic signed [N_FP-1:0] wr_val;

   assign cur      = prev_proc_elem[cnt];
   assign mag      = MW'(sat_mag(32'(cur), N_FP));
   assign sgn      = sign_of(32'(cur));
   assign acc_init = (state == IDLE) && start;
   assign scan_upd = (state == SCAN) && !orphan;

   // Descending scan so the lowest-numbered check wins when an edge has several.
   always_comb begin
      chk_idx = '0;
      orphan  = 1'b1;
      for (int c = N_C - 1; c >= 0; c--) begin
         if (adj_matrix_out[c][cnt]) begin
            chk_idx = CW'(c);
            orphan  = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < N_C; g++) begin : g_acc
      minsum_cn_acc #(.MW(MW), .IW(IW), .E(E)) u_acc (
         .clk      (clk),
         .rst      (rst),
         .init     (acc_init),
         .upd      (scan_upd && (chk_idx == CW'(g))),
         .edge_idx (cnt),
         .mag_in   (mag),
         .sgn_in   (sgn),
         .ext_mag  (ext_mag[g]),
         .par      (par[g])
      );
   end

`ifdef CHECK_OFFSET_EN
   always_comb begin
      out_mag = (sel_mag > MW'(OFFSET)) ? (sel_mag - MW'(OFFSET)) : '0;
   end
`else
   localparam int unused_offset = OFFSET;
   always_comb begin
      out_mag = sel_mag;
   end
`endif

   always_comb begin
      sel_mag = ext_mag[chk_idx];
      sel_sgn = par[chk_idx] ^ sgn;
      pos     = {1'b0, out_mag};
      wr_val  = orphan ? '0 : (sel_sgn ? -pos : pos);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         for (int e = 0; e < E; e++)
            proc_elem[e] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SCAN;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (cnt == LAST) begin
                  state <= WRITE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WRITE: begin
               proc_elem[cnt] <= wr_val;
               if (cnt == LAST) begin
                  state <= DONE;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_check_nodes_serial.sv
// Directed bench for check_nodes_serial on a 2-check, 6-edge graph.
module tb_check_nodes_serial;

   localparam int NC  = 2;
   localparam int NE  = 6;
   localparam int NFP = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic [0:NC-1][0:NE-1] adj;
   logic signed [NFP-1:0] ppe [0:NE-1];
   logic busy;
   logic done;
   logic signed [NFP-1:0] pe [0:NE-1];

   int checks = 0;
   int errors = 0;

   check_nodes_serial #(.N_C(NC), .E(NE), .N_FP(NFP), .OFFSET(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .adj_matrix_out (adj),
      .prev_proc_elem (ppe),
      .busy           (busy),
      .done           (done),
      .proc_elem      (pe)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic loadInputs(input logic [0:NC-1][0:NE-1] a, input int v[NE]);
      adj = a;
      for (int i = 0; i < NE; i++)
         ppe[i] = NFP'(v[i]);
   endtask

   // One full run: start pulse, cycle-accurate busy/done tracking, final outputs.
   task automatic applyStimulus(input string name, input logic [0:NC-1][0:NE-1] a,
                                input int v[NE], input int xp[NE], input int xo[NE],
                                input bit pulse_in_write);
      int done_cycle;
      int done_cnt;
      int busy_cnt;
      int overlap;
      int exp_e[NE];
      done_cycle = -1;
      done_cnt   = 0;
      busy_cnt   = 0;
      overlap    = 0;
`ifdef CHECK_OFFSET_EN
      exp_e = xo;
`else
      exp_e = xp;
`endif
      @(negedge clk);
      loadInputs(a, v);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 2 * NE + 3; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         start = pulse_in_write && (k == NE + 3);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cycle < 0) done_cycle = k;
         end
         if (busy && done) overlap++;
         if (k == NE + 2) checkOutput({name, " pe0_first_valid"}, pe[0], exp_e[0]);
      end
      start = 1'b0;
      checkOutput({name, " done_cycle"}, done_cycle, 2 * NE + 1);
      checkOutput({name, " done_count"}, done_cnt, 1);
      checkOutput({name, " busy_cycles"}, busy_cnt, 2 * NE);
      checkOutput({name, " busy_done_overlap"}, overlap, 0);
      for (int i = 0; i < NE; i++)
         checkOutput($sformatf("%s pe[%0d]", name, i), pe[i], exp_e[i]);
   endtask

   initial begin
      logic [0:NC-1][0:NE-1] a_split;
      logic [0:NC-1][0:NE-1] a_orph;
      int viol;
      a_split = {6'b111000, 6'b000111};
      a_orph  = {6'b100000, 6'b011110};
      adj = '0;
      for (int i = 0; i < NE; i++) ppe[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      for (int i = 0; i < NE; i++)
         checkOutput($sformatf("reset pe[%0d]", i), pe[i], 0);
      @(negedge clk) rst = 1'b1;

      applyStimulus("basic", a_split, '{5, -3, 7, -2, 4, -6},
                    '{-3, 5, -3, -4, 2, -2}, '{-2, 4, -2, -3, 1, -1}, 1'b1);
      applyStimulus("tie", a_split, '{4, 4, 9, 0, 0, 0},
                    '{4, 4, 4, 0, 0, 0}, '{3, 3, 3, 0, 0, 0}, 1'b0);
      applyStimulus("sat", a_split, '{-128, 10, 20, -128, -128, 5},
                    '{10, -20, -10, -5, -5, 127}, '{9, -19, -9, -4, -4, 126}, 1'b0);
      applyStimulus("orphan", a_orph, '{3, 2, -5, 6, -1, 9},
                    '{127, 1, -1, 1, -2, 0}, '{126, 0, 0, 0, -1, 0}, 1'b0);

      // Abort a run four cycles into SCAN; outputs from the last run must clear.
      @(negedge clk);
      loadInputs(a_split, '{5, -3, 7, -2, 4, -6});
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort done", done, 0);
      for (int i = 0; i < NE; i++)
         checkOutput($sformatf("abort pe[%0d]", i), pe[i], 0);
      viol = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done || busy) viol++;
      end
      checkOutput("abort no_done", viol, 0);
      @(negedge clk) rst = 1'b1;

      applyStimulus("after_abort", a_split, '{5, -3, 7, -2, 4, -6},
                    '{-3, 5, -3, -4, 2, -2}, '{-2, 4, -2, -3, 1, -1}, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
